// File: rtl/eatup_pkg.sv
// Shared types and constants for the button-to-direction command path.
package eatup_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_t;

  localparam int unsigned NUM_BTN        = 4;
  localparam int unsigned DEB_CYCLES_DEF = 1000000;
  localparam int unsigned CNT_W_DEF      = 20;

  // First set request at or above ptr, wrapping 3 -> 0; caller guarantees req != 0.
  function automatic dir_t rr_pick(input logic [NUM_BTN-1:0] req, input dir_t ptr);
    dir_t idx;
    rr_pick = ptr;
    for (int k = NUM_BTN - 1; k >= 0; k--) begin
      idx = ptr + dir_t'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button 2-flop synchroniser, stable-count debouncer and registered rise pulse.
module btn_debounce
  import eatup_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // The level only follows sync after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
      level_d <= level;
      press   <= level & ~level_d;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync_q2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/btn_dir_arbiter.sv
// Four debounced direction buttons shared round-robin onto one valid/ready command channel.
module btn_dir_arbiter
  import eatup_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTN-1:0]  btn_in,
  input  logic                cmd_ready,
  output logic                cmd_valid,
  output dir_t                cmd_dir,
  output logic [NUM_BTN-1:0]  btn_level,
  output logic                overrun
);

  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] pending_nxt;
  logic [NUM_BTN-1:0] clr_mask;
  arb_state_t         state;
  arb_state_t         state_nxt;
  dir_t               rr_ptr;
  dir_t               rr_ptr_nxt;
  dir_t               cmd_dir_nxt;
  logic               cmd_valid_nxt;
  logic               overrun_nxt;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
    btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn_in[i]),
      .level   (btn_level[i]),
      .press   (press[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cmd_valid <= 1'b0;
      cmd_dir   <= DIR_UP;
      rr_ptr    <= DIR_UP;
      pending   <= '0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_valid <= cmd_valid_nxt;
      cmd_dir   <= cmd_dir_nxt;
      rr_ptr    <= rr_ptr_nxt;
      pending   <= pending_nxt;
      overrun   <= overrun_nxt;
    end
  end

  // A press in the same cycle as its own handshake clear re-arms pending without overrun.
  always_comb begin
    state_nxt     = state;
    cmd_valid_nxt = cmd_valid;
    cmd_dir_nxt   = cmd_dir;
    rr_ptr_nxt    = rr_ptr;
    clr_mask      = '0;

    case (state)
      ST_IDLE: begin
        if (|pending) begin
          cmd_dir_nxt   = rr_pick(pending, rr_ptr);
          cmd_valid_nxt = 1'b1;
          state_nxt     = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (cmd_valid && cmd_ready) begin
          clr_mask      = 4'b0001 << cmd_dir;
          rr_ptr_nxt    = cmd_dir + 2'd1;
          cmd_valid_nxt = 1'b0;
          state_nxt     = ST_IDLE;
        end
      end
      default: begin
        state_nxt     = ST_IDLE;
        cmd_valid_nxt = 1'b0;
      end
    endcase

    pending_nxt = (pending & ~clr_mask) | press;
    overrun_nxt = |(press & pending & ~clr_mask);
  end

endmodule

// File: tb/tb_btn_dir_arbiter.sv
// Directed bench for btn_dir_arbiter with a short debounce window.
module tb_btn_dir_arbiter;
  import eatup_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_in;
  logic       cmd_ready;
  logic       cmd_valid;
  dir_t       cmd_dir;
  logic [3:0] btn_level;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  btn_dir_arbiter #(
    .DEB_CYCLES (4),
    .CNT_W      (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd_dir   (cmd_dir),
    .btn_level (btn_level),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output int n, output bit ok);
    n  = 0;
    ok = 1'b1;
    while (!cmd_valid) begin
      if (n >= budget) begin
        ok = 1'b0;
        break;
      end
      tick();
      n++;
    end
  endtask

  task automatic serve_pair(input string tag, input dir_t d1, input dir_t d2);
    int n;
    bit ok;
    int gap;
    wait_valid(30, n, ok);
    check({tag, "_first_seen"}, 32'(ok), 1);
    check({tag, "_first_dir"}, 32'(cmd_dir), 32'(d1));
    tick();
    gap = 1;
    while (!cmd_valid && gap < 10) begin
      tick();
      gap++;
    end
    check({tag, "_gap"}, 32'(gap), 2);
    check({tag, "_second_dir"}, 32'(cmd_dir), 32'(d2));
  endtask

  initial begin
    int  n;
    bit  ok;
    int  cnt_a;
    int  cnt_b;
    int  cnt_c;
    int  hs;

    reset     = 1'b1;
    btn_in    = 4'b0000;
    cmd_ready = 1'b0;
    #3;
    check("reset_valid", 32'(cmd_valid), 0);
    check("reset_dir", 32'(cmd_dir), 0);
    check("reset_level", 32'(btn_level), 0);
    check("reset_overrun", 32'(overrun), 0);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("post_reset_valid", 32'(cmd_valid), 0);

    // Test 1: reset while a command is being offered.
    btn_in = 4'b0010;
    wait_valid(20, n, ok);
    check("t1_offer_seen", 32'(ok), 1);
    check("t1_offer_dir", 32'(cmd_dir), 1);
    #2;
    reset = 1'b1;
    #1;
    check("t1_async_drop", 32'(cmd_valid), 0);
    check("t1_async_level", 32'(btn_level), 0);
    btn_in = 4'b0000;
    repeat (2) tick();
    reset = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cmd_valid) cnt_a++;
    end
    check("t1_no_cmd_after_reset", 32'(cnt_a), 0);

    // Test 2: clean press on left, latency and single command.
    cmd_ready = 1'b1;
    btn_in    = 4'b0100;
    n = 0;
    while (!btn_level[2] && n < 20) begin
      tick();
      n++;
    end
    check("t2_level_edges", 32'(n), 6);
    tick();
    check("t2_valid_k1", 32'(cmd_valid), 0);
    tick();
    check("t2_valid_k2", 32'(cmd_valid), 0);
    tick();
    check("t2_valid_k3", 32'(cmd_valid), 1);
    check("t2_dir", 32'(cmd_dir), 2);
    tick();
    check("t2_one_cycle", 32'(cmd_valid), 0);
    cnt_a = 0;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (cmd_valid) cnt_a++;
    end
    btn_in = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cmd_valid) cnt_a++;
    end
    check("t2_single_cmd", 32'(cnt_a), 0);
    check("t2_level_released", 32'(btn_level), 0);

    // Test 3: bouncing up button never debounces.
    cnt_a = 0;
    cnt_b = 0;
    cnt_c = 0;
    for (int i = 0; i < 8; i++) begin
      btn_in[0] = ~btn_in[0];
      repeat (2) begin
        tick();
        if (btn_level[0]) cnt_a++;
        if (cmd_valid) cnt_b++;
        if (overrun) cnt_c++;
      end
    end
    btn_in = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (btn_level[0]) cnt_a++;
      if (cmd_valid) cnt_b++;
      if (overrun) cnt_c++;
    end
    check("t3_level_low", 32'(cnt_a), 0);
    check("t3_no_cmd", 32'(cnt_b), 0);
    check("t3_no_overrun", 32'(cnt_c), 0);

    // Test 4: round-robin with rr_ptr freshly cleared by reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    btn_in = 4'b1001;
    serve_pair("t4_up_right", DIR_UP, DIR_RIGHT);
    btn_in = 4'b0000;
    repeat (12) tick();
    check("t4_idle_between", 32'(cmd_valid), 0);
    btn_in = 4'b0011;
    serve_pair("t4_up_down", DIR_UP, DIR_DOWN);
    btn_in = 4'b0000;
    repeat (12) tick();

    // Test 5: backpressure holds the offer; second press overruns once.
    cmd_ready = 1'b0;
    btn_in    = 4'b0100;
    wait_valid(20, n, ok);
    check("t5_offer_seen", 32'(ok), 1);
    check("t5_offer_dir", 32'(cmd_dir), 2);
    cnt_a = 0;
    cnt_c = 0;
    for (int i = 0; i < 42; i++) begin
      if (i == 2)  btn_in = 4'b0000;
      if (i == 14) btn_in = 4'b0100;
      if (i == 30) btn_in = 4'b0000;
      tick();
      if (!cmd_valid || cmd_dir !== DIR_LEFT) cnt_a++;
      if (overrun) cnt_c++;
    end
    check("t5_offer_stable", 32'(cnt_a), 0);
    check("t5_overrun_once", 32'(cnt_c), 1);
    cmd_ready = 1'b1;
    hs = 0;
    for (int i = 0; i < 11; i++) begin
      if (cmd_valid && cmd_ready) hs++;
      tick();
    end
    check("t5_handshakes", 32'(hs), 1);
    check("t5_pending_left", 32'(dut.pending[2]), 0);
    check("t5_valid_low", 32'(cmd_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/btn_dir_arbiter.md
Name: btn_dir_arbiter

Overview:
Turns four raw direction push-buttons (up, down, left, right) into one stream of direction commands for the game-logic movement engine. Each button is synchronised and debounced, and a debounced press becomes a pending request. A round-robin arbiter shares the single command channel among pending requests using a valid/ready handshake. The block sits between the board pins and the movement controller.

Parameters:
DEB_CYCLES, 1000000, stable-sample count before the debounced level changes (10 ms at 100 MHz); must be >= 2.
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
btn_in  input  4  raw asynchronous buttons; bit 0 = up, 1 = down, 2 = left, 3 = right; active-high.
cmd_ready  input  1  consumer can accept a command this cycle.
cmd_valid  output  1  cmd_dir holds a valid command.
cmd_dir  output  2  direction code: 0 up, 1 down, 2 left, 3 right.
btn_level  output  4  debounced button levels.
overrun  output  1  one-cycle pulse: a press arrived for a button that was already pending.

Behaviour:
- Reset is asynchronous and active-high; clock is clk. During and after reset, all of these are 0:
  - sync flops, debounced levels, counters, pending bits, rr_ptr;
  - cmd_valid, cmd_dir, btn_level, overrun.
  - The FSM is in IDLE.
- Reset mid-handshake: cmd_valid drops immediately, without waiting for a clock edge. The offered command is lost; no partial state survives.
- Synchroniser: 2 flops per button. sync[i] lags btn_in[i] by 2 edges.
- Debounce, per button:
  - If sync[i] == btn_level[i], the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals DEB_CYCLES-1 and sync still differs, btn_level[i] <= sync[i] and the counter clears.
  - Any bounce (sync returns to btn_level) before then clears the counter; the level does not change.
- Press detect: a registered rising edge of btn_level[i] produces press[i] one cycle after btn_level[i] rises. Releases generate nothing.
- Pending: press[i] sets pending[i] at the next edge.
  - If pending[i] is already 1 and not being cleared that cycle, the press is coalesced and overrun pulses for 1 cycle.
  - If the same button's press and its handshake clear happen in the same cycle, the press wins: pending stays 1 and there is no overrun.
- FSM IDLE:
  - If pending != 0, pick the first set bit searching upward from rr_ptr, wrapping 3 -> 0.
  - Load cmd_dir with that index, set cmd_valid = 1, go to OFFER.
  - Else stay in IDLE.
- FSM OFFER:
  - cmd_dir and cmd_valid are held stable until cmd_valid && cmd_ready. No retraction or change while waiting.
  - On handshake: clear pending[cmd_dir], rr_ptr <= cmd_dir+1 (mod 4), cmd_valid <= 0, go to IDLE.
- Throughput: at most one command per 2 cycles, because IDLE always costs one cycle. This is acceptable at human button rates.
- End-to-end latency: if btn_level rises at edge k, then press is at k+1, pending at k+2, and cmd_valid is high after edge k+3.
- cmd_ready is ignored in IDLE.
- Simultaneous presses: all become pending and are served in round-robin order starting at rr_ptr.

Decomposition:
- Shared package eatup_pkg holds:
  - direction codes DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3;
  - the 2-bit dir_t typedef;
  - the FSM state encoding (IDLE, OFFER);
  - the default DEB_CYCLES.
- One sub-module, btn_debounce: 2-flop synchroniser, counter, debounced level and registered rise pulse for a single button. It is instantiated 4 times.
- Pending register, round-robin pick and FSM stay in btn_dir_arbiter.

Test Plan:
1. Reset mid-OFFER, with DEB_CYCLES=4 for simulation: with cmd_valid=1 and cmd_ready=0, assert reset -> cmd_valid=0 immediately. Then deassert reset -> no command appears without a new press.
2. Clean debounce and latency: btn_in[2] 0->1 held 20 cycles, cmd_ready=1 -> btn_level[2] rises 2+4 edges after the input change. cmd_valid is high 3 edges after btn_level[2] rises, with cmd_dir=2 for exactly 1 cycle. Exactly one command is produced.
3. Bounce rejection: btn_in[0] toggles every 2 cycles for 16 cycles, then stays 0 -> btn_level[0] stays 0, cmd_valid never rises, overrun stays 0.
4. Round-robin: rr_ptr=0, up and right pressed in the same cycle, cmd_ready=1 -> commands are cmd_dir=0 then cmd_dir=3, 2 cycles apart. A following simultaneous up+down -> cmd_dir=0 then 1, because rr_ptr=0 after serving right.
5. Backpressure and overrun: cmd_ready=0, press left twice (released and debounced between presses) -> cmd_dir=2 held stable throughout. overrun pulses once on the second press. Raising cmd_ready then -> a single handshake, pending[2]=0.
